snake_dir_ctrl: RTL and testbench
=================================

// Module: snake_dir_ctrl
// PURPOSE
//  Upstream stage of vga_display. Merges debounced key events (four key_debounce
//  instances) and IR remote codes (remote_rcv) into one validated snake heading.
//  Buffers up to FIFO_DEPTH turn requests and commits one per game step_tick.
//  Rejects reversals and duplicates; provides an IR pause toggle.
// PARAMETERS
//  FIFO_DEPTH  2      pending-turn queue depth (power of 2, >=2)
//  IR_UP       8'h18  remote_rcv code mapped to UP
//  IR_DOWN     8'h52  code mapped to DOWN
//  IR_LEFT     8'h08  code mapped to LEFT
//  IR_RIGHT    8'h5A  code mapped to RIGHT
//  IR_PAUSE    8'h1C  code toggling pause
// PORTS
//  sys_clk      in   1  single clock; all inputs synchronous to it
//  sys_rst      in   1  synchronous reset, active-high
//  kf_up/down/left/right  in 1 each  key_flag: 1-cycle pulse, debounced edge
//  kv_up/down/left/right  in 1 each  key_value: 0 = pressed
//  ir_data_en   in   1  1-cycle pulse: ir_data valid
//  ir_repeat_en in   1  NEC repeat code seen; ignored (no auto-repeat)
//  ir_data      in   8  IR command byte
//  step_tick    in   1  1-cycle pulse: snake advances one cell
//  cur_dir      out  2  committed heading (UP=0,DOWN=1,LEFT=2,RIGHT=3)
//  dir_changed  out  1  1-cycle pulse, cycle after cur_dir changes
//  paused       out  1  1 = game paused
//  q_count      out  $clog2(FIFO_DEPTH)+1  pending requests
//  req_drop     out  1  1-cycle pulse: a request was discarded
// BEHAVIOUR
//  Reset (sys_rst=1 at edge): cur_dir=RIGHT, queue empty, q_count=0, paused=0,
//   dir_changed=0, req_drop=0. Reset mid-operation discards queue immediately.
//  Key request: kf_x & ~kv_x. IR request: ir_data_en & ir_data==IR_{dir}.
//  Same-cycle arbitration: IR > UP > DOWN > LEFT > RIGHT; only the winner is
//   evaluated; each loser pulses req_drop (single pulse per cycle regardless).
//  Unmapped IR byte: ignored, no drop pulse.
//  Reference dir ref = (q_count>0) ? queue tail : cur_dir (pre-pop value).
//  Accept iff req != ref && req != (ref^2'b01) && !paused && !full-after-pop.
//   Equal to ref: silently ignored. Opposite/paused/full: req_drop=1.
//  Full-after-pop: q_count==FIFO_DEPTH && !(step_tick && !paused).
//  Commit: step_tick & !paused & q_count>0 -> cur_dir<=head, pop, dir_changed=1
//   next cycle. step_tick with empty queue: no change.
//  Simultaneous push+pop: both occur; q_count unchanged; order preserved.
//  IR_PAUSE with ir_data_en toggles paused; ir_repeat_en never toggles.
//   Pausing keeps queue contents; step_tick ignored while paused.
//  Latency: request -> q_count update 1 cycle; step_tick -> cur_dir 1 cycle.
//  All outputs registered; no combinational input->output path.
// STRUCTURE
//  snake_pkg: dir_t encoding (UP=0..RIGHT=3), OPPOSITE(d)=d^1, DIR_RESET=RIGHT,
//   IR code defaults shared with vga_display/remote_rcv users.
//  Sub-module dir_fifo: FIFO_DEPTH x 2-bit, push/pop/same-cycle, exposes
//   head, tail, count; sync active-high reset. Arbiter + accept logic in top.
// TESTING
//  1 Reset, then 3 step_ticks, no input -> cur_dir=3, dir_changed never pulses.
//  2 kf_up&~kv_up, then step_tick -> q_count 0->1->0, cur_dir=0, dir_changed 1 cyc.
//  3 cur_dir=RIGHT, push LEFT -> req_drop pulse, q_count=0; push RIGHT -> no drop.
//  4 UP then LEFT queued (count=2), DOWN pushed -> dropped (full); 2 ticks ->
//    cur_dir 0 then 2; push with tick at count=2 -> accepted, count stays 2.
//  5 ir_data=8'h52 & kf_left same cycle -> IR wins (DOWN queued), req_drop=1.
//  6 IR 8'h1C -> paused=1; step_tick with count=1 -> no commit; repeat_en -> still
//    paused; IR 8'h1C -> paused=0; tick commits queued dir.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared heading encoding, reset heading and IR command defaults
package snake_pkg;
    typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
    localparam dir_t DIR_RESET = RIGHT;
    localparam logic [7:0] IR_UP_CODE    = 8'h18;
    localparam logic [7:0] IR_DOWN_CODE  = 8'h52;
    localparam logic [7:0] IR_LEFT_CODE  = 8'h08;
    localparam logic [7:0] IR_RIGHT_CODE = 8'h5A;
    localparam logic [7:0] IR_PAUSE_CODE = 8'h1C;
    // Headings are paired so that flipping bit 0 gives the reverse direction
    function automatic logic [1:0] opposite(logic [1:0] d);
        return d ^ 2'b01;
    endfunction
endpackage

// File: rtl/dir_fifo.sv
// dir_fifo: small heading queue with same-cycle push/pop and visible head/tail
module dir_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [1:0]               din,
    output logic [1:0]               head,
    output logic [1:0]               tail,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    assign head = mem[rd_ptr];
    assign tail = mem[wr_ptr - 1'b1];
endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: merges key/IR turn requests into a validated, step-committed heading
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [7:0] IR_UP      = IR_UP_CODE,
    parameter logic [7:0] IR_DOWN    = IR_DOWN_CODE,
    parameter logic [7:0] IR_LEFT    = IR_LEFT_CODE,
    parameter logic [7:0] IR_RIGHT   = IR_RIGHT_CODE,
    parameter logic [7:0] IR_PAUSE   = IR_PAUSE_CODE
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          kf_up,
    input  logic                          kf_down,
    input  logic                          kf_left,
    input  logic                          kf_right,
    input  logic                          kv_up,
    input  logic                          kv_down,
    input  logic                          kv_left,
    input  logic                          kv_right,
    input  logic                          ir_data_en,
    input  logic                          ir_repeat_en,
    input  logic [7:0]                    ir_data,
    input  logic                          step_tick,
    output logic [1:0]                    cur_dir,
    output logic                          dir_changed,
    output logic                          paused,
    output logic [$clog2(FIFO_DEPTH):0]   q_count,
    output logic                          req_drop
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic       ir_u, ir_d, ir_l, ir_r, ir_any, ir_pause;
    logic       k_u, k_d, k_l, k_r, any_req, losers;
    logic       run, pop, full, push, drop;
    logic [1:0] req, ref_dir, head, tail;
    logic       unused_repeat;
    assign unused_repeat = ir_repeat_en;
    assign ir_u     = ir_data_en && ir_data == IR_UP;
    assign ir_d     = ir_data_en && ir_data == IR_DOWN;
    assign ir_l     = ir_data_en && ir_data == IR_LEFT;
    assign ir_r     = ir_data_en && ir_data == IR_RIGHT;
    assign ir_pause = ir_data_en && ir_data == IR_PAUSE;
    assign ir_any   = ir_u | ir_d | ir_l | ir_r;
    assign k_u      = kf_up & ~kv_up;
    assign k_d      = kf_down & ~kv_down;
    assign k_l      = kf_left & ~kv_left;
    assign k_r      = kf_right & ~kv_right;
    assign any_req  = ir_any | k_u | k_d | k_l | k_r;
    assign losers   = $countones({ir_any, k_u, k_d, k_l, k_r}) > 1;
    always_comb begin
        req = ir_any ? (ir_u ? UP : ir_d ? DOWN : ir_l ? LEFT : RIGHT)
                     : (k_u ? UP : k_d ? DOWN : k_l ? LEFT : RIGHT);
    end
    // New requests are judged against the last queued turn, not the live heading
    assign ref_dir = (q_count != '0) ? tail : cur_dir;
    assign run     = step_tick & ~paused;
    assign pop     = run && q_count != '0;
    assign full    = q_count == CW'(FIFO_DEPTH) && !run;
    assign push    = any_req && req != ref_dir && req != opposite(ref_dir) && !paused && !full;
    assign drop    = losers || (any_req && req != ref_dir && !push);
    dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push),
        .pop   (pop),
        .din   (req),
        .head  (head),
        .tail  (tail),
        .count (q_count)
    );
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cur_dir     <= DIR_RESET;
            dir_changed <= 1'b0;
            paused      <= 1'b0;
            req_drop    <= 1'b0;
        end else begin
            cur_dir     <= pop ? head : cur_dir;
            dir_changed <= pop;
            paused      <= paused ^ ir_pause;
            req_drop    <= drop;
        end
    end
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed scenarios plus randomized traffic against a queue-based heading model
module tb_snake_dir_ctrl;
    logic       clk = 0, rst = 1;
    logic [3:0] kf = 0, kv = 4'hF;
    logic       ir_en = 0, ir_rep = 0, tick = 0;
    logic [7:0] ir_data = 0;
    logic [1:0] cur_dir, q_count;
    logic       dir_changed, paused, req_drop;
    int n_chk = 0, n_err = 0;
    always #5 clk = ~clk;

    snake_dir_ctrl dut (
        .sys_clk(clk), .sys_rst(rst),
        .kf_up(kf[0]), .kf_down(kf[1]), .kf_left(kf[2]), .kf_right(kf[3]),
        .kv_up(kv[0]), .kv_down(kv[1]), .kv_left(kv[2]), .kv_right(kv[3]),
        .ir_data_en(ir_en), .ir_repeat_en(ir_rep), .ir_data(ir_data),
        .step_tick(tick), .cur_dir(cur_dir), .dir_changed(dir_changed),
        .paused(paused), .q_count(q_count), .req_drop(req_drop)
    );

    // Model: pending turns as a queue, heading index equals key index (0=UP..3=RIGHT)
    logic [7:0] dir_codes [4] = '{8'h18, 8'h52, 8'h08, 8'h5A};
    logic [1:0] mq [$];
    logic [1:0] reqs [$];
    logic [1:0] m_dir, ref_d;
    logic       m_paused, m_chg, m_drop, adv, push_me;
    bit         chk_en = 0;
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_dir = 2'd3; m_paused = 0; m_chg = 0; m_drop = 0; chk_en = 1;
        end else begin
            reqs.delete();
            push_me = 0;
            if (ir_en) for (int d = 0; d < 4; d++) if (ir_data == dir_codes[d]) reqs.push_back(2'(d));
            for (int d = 0; d < 4; d++) if (kf[d] && !kv[d]) reqs.push_back(2'(d));
            adv    = tick && !m_paused;
            ref_d  = mq.size() > 0 ? mq[$] : m_dir;
            m_drop = reqs.size() > 1;
            if (reqs.size() > 0 && reqs[0] != ref_d) begin
                if (reqs[0] == (ref_d ^ 2'b01) || m_paused || (mq.size() == 2 && !adv)) m_drop = 1;
                else push_me = 1;
            end
            m_chg = adv && mq.size() > 0;
            if (m_chg) m_dir = mq.pop_front();
            if (push_me) mq.push_back(reqs[0]);
            if (ir_en && ir_data == 8'h1C) m_paused = !m_paused;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (cur_dir !== m_dir || dir_changed !== m_chg || paused !== m_paused ||
                q_count !== 2'(mq.size()) || req_drop !== m_drop) begin
                n_err++;
                $display("FAIL model t=%0t got dir=%0d chg=%0b pau=%0b cnt=%0d drop=%0b want dir=%0d chg=%0b pau=%0b cnt=%0d drop=%0b",
                         $time, cur_dir, dir_changed, paused, q_count, req_drop,
                         m_dir, m_chg, m_paused, mq.size(), m_drop);
            end
        end
    end

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] k, logic ie, logic [7:0] d, logic t, logic rp);
        kf = k; kv = ~k; ir_en = ie; ir_data = d; tick = t; ir_rep = rp;
        @(posedge clk); #1;
        kf = 0; kv = 4'hF; ir_en = 0; tick = 0; ir_rep = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        // 1: reset values, ticks with nothing queued
        do_reset();
        check("rst_dir", cur_dir, 3); check("rst_cnt", q_count, 0);
        check("rst_pause", paused, 0); check("rst_drop", req_drop, 0); check("rst_chg", dir_changed, 0);
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 0, 8'h00, 1, 0);
            check("idle_tick_dir", cur_dir, 3); check("idle_tick_chg", dir_changed, 0);
        end
        // 2: key UP then commit
        drive(4'b0001, 0, 8'h00, 0, 0);
        check("up_cnt", q_count, 1); check("up_dir_before", cur_dir, 3);
        drive(4'b0000, 0, 8'h00, 1, 0);
        check("up_dir", cur_dir, 0); check("up_chg", dir_changed, 1); check("up_cnt0", q_count, 0);
        drive(4'b0000, 0, 8'h00, 0, 0);
        check("up_chg_end", dir_changed, 0);
        // 3: reversal dropped, duplicate ignored silently
        do_reset();
        drive(4'b0100, 0, 8'h00, 0, 0);
        check("rev_drop", req_drop, 1); check("rev_cnt", q_count, 0);
        drive(4'b1000, 0, 8'h00, 0, 0);
        check("dup_drop", req_drop, 0); check("dup_cnt", q_count, 0);
        // 4: fill, overflow, drain, push-with-pop at full
        drive(4'b0001, 0, 8'h00, 0, 0);
        drive(4'b0100, 0, 8'h00, 0, 0);
        check("fill_cnt", q_count, 2);
        drive(4'b0010, 0, 8'h00, 0, 0);
        check("full_drop", req_drop, 1); check("full_cnt", q_count, 2);
        drive(4'b0000, 0, 8'h00, 1, 0);
        check("drain1_dir", cur_dir, 0);
        drive(4'b0000, 0, 8'h00, 1, 0);
        check("drain2_dir", cur_dir, 2); check("drain_cnt", q_count, 0);
        drive(4'b0001, 0, 8'h00, 0, 0);
        drive(4'b1000, 0, 8'h00, 0, 0);
        check("refill_cnt", q_count, 2);
        drive(4'b0010, 0, 8'h00, 1, 0);
        check("pushpop_cnt", q_count, 2); check("pushpop_dir", cur_dir, 0); check("pushpop_drop", req_drop, 0);
        // 5: IR beats key, mid-run reset clears queue
        do_reset();
        check("midrst_cnt", q_count, 0); check("midrst_dir", cur_dir, 3);
        drive(4'b0100, 1, 8'h52, 0, 0);
        check("ir_win_cnt", q_count, 1); check("ir_win_drop", req_drop, 1);
        // 6: pause holds queue, repeat code ignored
        drive(4'b0000, 1, 8'h1C, 0, 0);
        check("pause_on", paused, 1);
        drive(4'b0000, 0, 8'h00, 1, 0);
        check("pause_dir", cur_dir, 3); check("pause_cnt", q_count, 1); check("pause_chg", dir_changed, 0);
        drive(4'b0000, 0, 8'h1C, 0, 1);
        check("repeat_pause", paused, 1);
        drive(4'b0000, 1, 8'h1C, 0, 0);
        check("pause_off", paused, 0);
        drive(4'b0000, 0, 8'h00, 1, 0);
        check("resume_dir", cur_dir, 1); check("resume_cnt", q_count, 0); check("resume_chg", dir_changed, 1);
        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            int idx;
            rst = ($urandom_range(299) == 0);
            for (int b = 0; b < 4; b++) begin
                kf[b] = ($urandom_range(5) == 0);
                kv[b] = ($urandom_range(3) == 0);
            end
            ir_en  = ($urandom_range(7) == 0);
            ir_rep = ($urandom_range(9) == 0);
            tick   = ($urandom_range(3) == 0);
            idx = $urandom_range(6);
            ir_data = idx < 4 ? dir_codes[idx] : idx == 4 ? 8'h1C : 8'($urandom);
            @(posedge clk); #1;
        end
        rst = 0; kf = 0; kv = 4'hF; ir_en = 0; ir_rep = 0; tick = 0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
